// File: rtl/cascade_pkg.sv
// Shared types and address mapping for the cascade-classifier variance path.
// var_to_addr() is the single definition of variance -> sqrt ROM address.
package cascade_pkg;

    localparam int DEF_WIN_AREA  = 576;
    localparam int DEF_W_SUM     = 18;
    localparam int DEF_W_SQSUM   = 26;
    localparam int DEF_W_ADDR    = 8;
    localparam int DEF_VAR_SHIFT = 27;

    localparam int W_NQ_DEF = DEF_W_SQSUM + $clog2(DEF_WIN_AREA + 1);
    localparam int W_VAR    = ((W_NQ_DEF > 2 * DEF_W_SUM) ? W_NQ_DEF : 2 * DEF_W_SUM) + 1;

    typedef logic signed [W_VAR-1:0]      var_t;
    typedef logic        [DEF_W_ADDR-1:0] sqrt_addr_t;

    // Negative variance maps to 0; any index bit above the ROM range saturates.
    function automatic sqrt_addr_t var_to_addr(input var_t v, input int shift);
        var_t idx;
        if (v[W_VAR-1]) return '0;
        idx = v >>> shift;
        if (|idx[W_VAR-1:DEF_W_ADDR]) return '1;
        return idx[DEF_W_ADDR-1:0];
    endfunction

endpackage

// File: rtl/var_addr_gen.sv
// Window variance N*Q - S*S -> sqrt ROM address, 3-stage stallable pipeline.
// Optional saturation counter on sat_cnt built only when VAR_SAT_CNT_EN is defined.
module var_addr_gen
    import cascade_pkg::*;
#(
    parameter int WIN_AREA  = DEF_WIN_AREA,
    parameter int W_SUM     = DEF_W_SUM,
    parameter int W_SQSUM   = DEF_W_SQSUM,
    parameter int W_ADDR    = DEF_W_ADDR,
    parameter int VAR_SHIFT = DEF_VAR_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               win_valid,
    output logic               win_ready,
    input  logic [W_SUM-1:0]   win_sum,
    input  logic [W_SQSUM-1:0] win_sqsum,
    output logic               addr_valid,
    input  logic               addr_ready,
    output logic [W_ADDR-1:0]  addr_data,
    output logic [15:0]        sat_cnt
);

    localparam int W_NQ = W_SQSUM + $clog2(WIN_AREA + 1);
    localparam int W_SS = 2 * W_SUM;

    logic            adv;
    logic            vld1_q, vld2_q, vld3_q;
    logic [W_NQ-1:0] nq_q;
    logic [W_SS-1:0] ss_q;
    var_t            diff_raw, diff_d, diff_q;
    sqrt_addr_t      addr_q;

    // Every stage moves together whenever the output slot is free or draining.
    assign adv        = !vld3_q || addr_ready;
    assign win_ready  = adv;
    assign addr_valid = vld3_q;
    assign addr_data  = addr_q;

    always_comb begin
        diff_raw = var_t'(nq_q) - var_t'(ss_q);
        diff_d   = diff_raw[W_VAR-1] ? '0 : diff_raw;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
            addr_q <= '0;
        end else if (adv) begin
            vld1_q <= win_valid;
            vld2_q <= vld1_q;
            vld3_q <= vld2_q;
            if (vld2_q) addr_q <= var_to_addr(diff_q, VAR_SHIFT);
        end
    end

    // Wide arithmetic registers carry no reset; validity is tracked by vld*_q.
    always_ff @(posedge clk) begin
        if (adv) begin
            nq_q   <= W_NQ'(win_sqsum) * W_NQ'(WIN_AREA);
            ss_q   <= W_SS'(win_sum) * W_SS'(win_sum);
            diff_q <= diff_d;
        end
    end

`ifdef VAR_SAT_CNT_EN
    logic        sat3_q;
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat3_q    <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (adv && vld2_q) sat3_q <= |(diff_q >> (VAR_SHIFT + W_ADDR));
            if (vld3_q && addr_ready && sat3_q && sat_cnt_q != 16'hFFFF)
                sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_var_addr_gen.sv
// Randomized and directed bench for var_addr_gen with a queue-based reference model.
module tb_var_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        win_valid, win_ready;
    logic [17:0] win_sum;
    logic [25:0] win_sqsum;
    logic        addr_valid, addr_ready;
    logic [7:0]  addr_data;
    logic [15:0] sat_cnt;

    var_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_sum    (win_sum),
        .win_sqsum  (win_sqsum),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_data  (addr_data),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint a;
        bit     sat;
    } exp_t;

    int     n_checks = 0;
    int     n_err    = 0;
    int     n_out    = 0;
    longint exp_sat  = 0;
    exp_t   sb[$];
    exp_t   e;
    bit     prev_stall = 1'b0;
    longint prev_data  = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: variance in plain 64-bit arithmetic, floor-divide by 2^27, clamp to ROM.
    function automatic exp_t model(input longint s, input longint q);
        exp_t   r;
        longint v;
        longint idx;
        v = 576 * q - s * s;
        if (v < 0) v = 0;
        idx   = v / 134217728;
        r.sat = (idx > 255);
        r.a   = r.sat ? 255 : idx;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            prev_stall = 1'b0;
            exp_sat    = 0;
        end else begin
            check("sat_cnt", sat_cnt, exp_sat);
            if (prev_stall) begin
                check("hold_valid", addr_valid, 1);
                check("hold_data", addr_data, prev_data);
            end
            if (addr_ready || !addr_valid)
                check("win_ready_free", win_ready, 1);
            else if (sb.size() == 3)
                check("win_ready_full", win_ready, 0);
            if (sb.size() == 0 && addr_valid)
                check("spurious_out", addr_valid, 0);
            if (addr_valid && addr_ready && sb.size() > 0) begin
                e = sb.pop_front();
                n_out++;
                check("addr_data", addr_data, e.a);
`ifdef VAR_SAT_CNT_EN
                if (e.sat && exp_sat < 65535) exp_sat++;
`endif
            end
            if (win_valid && win_ready) sb.push_back(model(win_sum, win_sqsum));
            prev_stall = addr_valid && !addr_ready;
            prev_data  = addr_data;
        end
    end

    task automatic one_window(input string tag, input logic [17:0] s, input logic [25:0] q);
        int n;
        @(posedge clk); #1;
        win_valid = 1'b1; win_sum = s; win_sqsum = q; addr_ready = 1'b1;
        @(posedge clk); #1;
        win_valid = 1'b0;
        n = 1;
        while (!addr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, 3);
    endtask

    task automatic drain(input string tag);
        int n;
        win_valid  = 1'b0;
        addr_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, c, base;
        bit          acc;
        logic [31:0] r;
        int          ovr;

        win_valid = 1'b0; addr_ready = 1'b1; win_sum = '0; win_sqsum = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr_valid", addr_valid, 0);
        check("rst_addr_data", addr_data, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("win_ready_after_rst", win_ready, 1);

        one_window("t1", 18'd0, 26'd0);
        check("t1_addr", addr_data, 0);
        one_window("t2a", 18'd0, 26'd2097152);
        check("t2a_addr", addr_data, 9);
        one_window("t2b", 18'd0, 26'd2097151);
        check("t2b_addr", addr_data, 8);
        one_window("t3", 18'd0, 26'd67108863);
        check("t3_addr", addr_data, 255);
        @(posedge clk); #1;
`ifdef VAR_SAT_CNT_EN
        check("t3_sat_cnt", sat_cnt, 1);
`else
        check("t3_sat_cnt", sat_cnt, 0);
`endif
        one_window("t4", 18'd1, 26'd0);
        check("t4_addr", addr_data, 0);
        @(posedge clk); #1;
`ifdef VAR_SAT_CNT_EN
        check("t4_sat_cnt", sat_cnt, 1);
`else
        check("t4_sat_cnt", sat_cnt, 0);
`endif

        // Back-pressure: six windows, output stalled for cycles 2..7.
        base = n_out;
        k = 1; c = 1;
        while (k <= 6 && c <= 40) begin
            win_valid  = 1'b1;
            win_sum    = '0;
            win_sqsum  = 26'(k << 21);
            addr_ready = !(c >= 2 && c <= 7);
            #2;
            acc = win_valid && win_ready;
            if (c >= 4 && c <= 7) check("bp_ready_low", win_ready, 0);
            @(posedge clk); #1;
            if (acc) k++;
            c++;
        end
        check("bp_accepted", k, 7);
        drain("bp");
        check("bp_count", n_out - base, 6);

        // Reset with two windows in flight, one of them already presented.
        @(posedge clk); #1;
        win_valid = 1'b1; win_sum = '0; win_sqsum = 26'(1 << 21); addr_ready = 1'b1;
        @(posedge clk); #1;
        win_sqsum = 26'(2 << 21);
        @(posedge clk); #1;
        win_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_valid_before_rst", addr_valid, 1);
        rst = 1'b0;
        #1;
        check("t6_valid_in_rst", addr_valid, 0);
        check("t6_data_in_rst", addr_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("t6_no_stale", addr_valid, 0);
        end
        one_window("t6", 18'd0, 26'(3 << 21));
        check("t6_addr", addr_data, 27);
        drain("t6");

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            win_valid  = ($urandom_range(0, 3) != 0);
            addr_ready = ($urandom_range(0, 3) != 0);
            r = $urandom;
            ovr = $urandom_range(0, 2);
            if (ovr == 0)      win_sum = r[17:0];
            else if (ovr == 1) win_sum = {6'd0, r[11:0]};
            else               win_sum = '0;
            r = $urandom;
            win_sqsum = r[25:0];
        end
        drain("rand");
        @(posedge clk); #1;
        check("final_sat_cnt", sat_cnt, exp_sat);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
